// File: rtl/display_adapter_pkg.sv
// Shared definitions for the display adapter: default geometry, the
// per-bank state encoding and a small debug view of the ping-pong controller.
package display_adapter_pkg;

    localparam int DEFAULT_DEPTH = 10000;
    localparam int DEFAULT_AW    = 20;

    // Lifecycle of one frame bank.
    typedef enum logic [1:0] {
        BANK_EMPTY    = 2'd0,
        BANK_FILLING  = 2'd1,
        BANK_FULL     = 2'd2,
        BANK_DRAINING = 2'd3
    } bank_state_t;

    // Snapshot of the controller FSM: both bank states and both bank pointers.
    typedef struct packed {
        bank_state_t bank1;
        bank_state_t bank0;
        logic        wbank;
        logic        rbank;
    } debug_t;

    // A bank accepts pixels while it is not holding a complete frame.
    function automatic logic is_writable(input bank_state_t s);
        return (s == BANK_EMPTY) || (s == BANK_FILLING);
    endfunction

    // A bank can be read once it holds a complete frame.
    function automatic logic is_readable(input bank_state_t s);
        return (s == BANK_FULL) || (s == BANK_DRAINING);
    endfunction

endpackage

// File: rtl/pixel_addr_cnt.sv
// Pixel address counter: advances on enable, wraps to zero after DEPTH-1,
// and flags the last address of a frame so the owner can close the bank.
module pixel_addr_cnt
    import display_adapter_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = DEFAULT_AW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    output logic [AW-1:0] count,
    output logic          last
);

    localparam logic [AW-1:0] LAST_VALUE = AW'(DEPTH - 1);

    assign last = (count == LAST_VALUE);

    // Count enabled transfers; the value never exceeds DEPTH-1.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (en) begin
            count <= last ? '0 : count + AW'(1);
        end
    end

endmodule

// File: rtl/pingpong_buf_ctrl.sv
// Ping-pong frame buffer controller. A source fills one bank while the
// display drains the other; banks swap roles at frame boundaries.
//
// Handshakes: the write side transfers a pixel in every cycle where
// wr_valid && wr_ready are both high; wr_valid may be held across stalls.
// The read side has no back-pressure: rd_req is either serviced in its own
// cycle (readable bank available) or dropped and recorded in underflow.
module pingpong_buf_ctrl
    import display_adapter_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = DEFAULT_AW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_valid,
    input  logic [31:0]   wr_data,
    output logic          wr_ready,
    output logic [1:0]    buf_we,
    output logic [AW-1:0] buf_waddr,
    output logic [31:0]   buf_wdata,
    input  logic          rd_req,
    output logic [1:0]    buf_re,
    output logic [AW-1:0] buf_raddr,
    output logic          rd_valid,
    output logic          rd_bank,
    output logic [1:0]    bank_full,
    output logic          frame_done,
    output logic          underflow,
    output debug_t        debug
);

    bank_state_t   bank_state [2];
    bank_state_t   state_next [2];
    logic          wbank;
    logic          rbank;
    logic          wbank_next;
    logic          rbank_next;
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          wlast;
    logic          rlast;
    logic          wr_accept;
    logic          rd_ok;
    logic          rd_service;

    assign wr_accept  = wr_valid && wr_ready;
    assign rd_ok      = is_readable(bank_state[rbank]);
    assign rd_service = rd_req && rd_ok;

    pixel_addr_cnt #(.DEPTH(DEPTH), .AW(AW)) u_wr_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (wr_accept),
        .count (wptr),
        .last  (wlast)
    );

    pixel_addr_cnt #(.DEPTH(DEPTH), .AW(AW)) u_rd_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (rd_service),
        .count (rptr),
        .last  (rlast)
    );

    // Next bank states and pointers; a write and a read never target the
    // same bank because a bank is either writable or readable, never both.
    always_comb begin
        for (int n = 0; n < 2; n++) begin
            state_next[n] = bank_state[n];
            if (wr_accept && (wbank == 1'(n))) begin
                state_next[n] = wlast ? BANK_FULL : BANK_FILLING;
            end
            if (rd_service && (rbank == 1'(n))) begin
                state_next[n] = rlast ? BANK_EMPTY : BANK_DRAINING;
            end
        end
        wbank_next = (wr_accept && wlast) ? ~wbank : wbank;
        rbank_next = (rd_service && rlast) ? ~rbank : rbank;
    end

    // Bank FSM and pointers; wr_ready is registered from the next state so it
    // stays low through reset and rises one cycle after reset is released.
    always_ff @(posedge clk) begin
        if (reset) begin
            bank_state[0] <= BANK_EMPTY;
            bank_state[1] <= BANK_EMPTY;
            wbank         <= 1'b0;
            rbank         <= 1'b0;
            wr_ready      <= 1'b0;
        end else begin
            bank_state[0] <= state_next[0];
            bank_state[1] <= state_next[1];
            wbank         <= wbank_next;
            rbank         <= rbank_next;
            wr_ready      <= is_writable(state_next[wbank_next]);
        end
    end

    // Registered bank-port drive, read-valid pipeline and status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            buf_we     <= '0;
            buf_waddr  <= '0;
            buf_wdata  <= '0;
            buf_re     <= '0;
            buf_raddr  <= '0;
            rd_valid   <= 1'b0;
            rd_bank    <= 1'b0;
            frame_done <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            buf_we <= wr_accept ? (wbank ? 2'b10 : 2'b01) : 2'b00;
            if (wr_accept) begin
                buf_waddr <= wptr;
                buf_wdata <= wr_data;
            end
            buf_re <= rd_service ? (rbank ? 2'b10 : 2'b01) : 2'b00;
            if (rd_service) begin
                buf_raddr <= rptr;
            end
            // Bank RAM returns data one cycle after buf_re.
            rd_valid   <= |buf_re;
            rd_bank    <= buf_re[1];
            frame_done <= rd_service && rlast;
            underflow  <= underflow || (rd_req && !rd_ok);
        end
    end

    assign bank_full[0] = is_readable(bank_state[0]);
    assign bank_full[1] = is_readable(bank_state[1]);

    assign debug = '{bank1: bank_state[1], bank0: bank_state[0],
                     wbank: wbank, rbank: rbank};

endmodule

// File: tb/tb_pingpong_buf_ctrl.sv
// Testbench for pingpong_buf_ctrl with DEPTH=8. A frame-level model tracks
// how many pixels each bank holds and how many have been read out.
module tb_pingpong_buf_ctrl;
    import display_adapter_pkg::*;

    localparam int DEPTH = 8;
    localparam int AW    = 4;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          wr_valid = 1'b0;
    logic [31:0]   wr_data = '0;
    logic          rd_req = 1'b0;
    logic          wr_ready;
    logic [1:0]    buf_we;
    logic [AW-1:0] buf_waddr;
    logic [31:0]   buf_wdata;
    logic [1:0]    buf_re;
    logic [AW-1:0] buf_raddr;
    logic          rd_valid;
    logic          rd_bank;
    logic [1:0]    bank_full;
    logic          frame_done;
    logic          underflow;
    debug_t        debug;

    always #5 clk = ~clk;

    pingpong_buf_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_valid   (wr_valid),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .buf_we     (buf_we),
        .buf_waddr  (buf_waddr),
        .buf_wdata  (buf_wdata),
        .rd_req     (rd_req),
        .buf_re     (buf_re),
        .buf_raddr  (buf_raddr),
        .rd_valid   (rd_valid),
        .rd_bank    (rd_bank),
        .bank_full  (bank_full),
        .frame_done (frame_done),
        .underflow  (underflow),
        .debug      (debug)
    );

    // ---------------- reference model / scoreboard ----------------
    int          checks = 0;
    int          errors = 0;
    int          m_fill [2];
    int          m_drain [2];
    int          m_wbank;
    int          m_rbank;
    bit          m_under;
    bit          m_post_reset;
    bit          m_svc_prev;
    int          m_svc_bank_prev;
    logic [31:0] exp_q [$];
    logic [31:0] next_pix;
    bit          acc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic model_clear();
        m_fill[0] = 0; m_fill[1] = 0;
        m_drain[0] = 0; m_drain[1] = 0;
        m_wbank = 0; m_rbank = 0;
        m_under = 1'b0;
        m_svc_prev = 1'b0; m_svc_bank_prev = 0;
        exp_q.delete();
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        reset = 1'b1; wr_valid = 1'b0; rd_req = 1'b0; wr_data = '0;
        @(posedge clk); #1;
        chk("rst_wr_ready",   32'(wr_ready),   32'd0);
        chk("rst_buf_we",     32'(buf_we),     32'd0);
        chk("rst_buf_re",     32'(buf_re),     32'd0);
        chk("rst_waddr",      32'(buf_waddr),  32'd0);
        chk("rst_raddr",      32'(buf_raddr),  32'd0);
        chk("rst_wdata",      buf_wdata,       32'd0);
        chk("rst_rd_valid",   32'(rd_valid),   32'd0);
        chk("rst_rd_bank",    32'(rd_bank),    32'd0);
        chk("rst_bank_full",  32'(bank_full),  32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_underflow",  32'(underflow),  32'd0);
        chk("rst_debug",      32'(debug),      32'd0);
        reset = 1'b0;
        model_clear();
        m_post_reset = 1'b1;
    endtask

    // One clock cycle with the given inputs; checks everything registered
    // from this cycle's transfers and reports whether the write was taken.
    task automatic step(input logic wv, input logic [31:0] wd, input logic rq, output bit acc_o);
        bit exp_ready, a, svc, rl;
        int wb, rb, wa, ra;
        wr_valid = wv; wr_data = wd; rd_req = rq;
        exp_ready = !m_post_reset && (m_fill[m_wbank] < DEPTH);
        chk("wr_ready", 32'(wr_ready), 32'(exp_ready));
        a   = wv && exp_ready;
        svc = rq && (m_fill[m_rbank] == DEPTH);
        wb = m_wbank; rb = m_rbank;
        wa = m_fill[wb]; ra = m_drain[rb];
        rl = 1'b0;
        if (a) begin
            exp_q.push_back(wd);
            m_fill[wb]++;
            if (m_fill[wb] == DEPTH) m_wbank = 1 - m_wbank;
        end
        if (svc) begin
            m_drain[rb]++;
            if (m_drain[rb] == DEPTH) begin
                m_drain[rb] = 0; m_fill[rb] = 0;
                m_rbank = 1 - m_rbank;
                rl = 1'b1;
            end
        end
        if (rq && !svc) m_under = 1'b1;
        m_post_reset = 1'b0;
        @(posedge clk); #1;
        chk("buf_we", 32'(buf_we), a ? ((wb == 1) ? 32'd2 : 32'd1) : 32'd0);
        if (a) begin
            chk("buf_waddr", 32'(buf_waddr), 32'(wa));
            chk("buf_wdata", buf_wdata, exp_q.pop_front());
        end
        chk("buf_re", 32'(buf_re), svc ? ((rb == 1) ? 32'd2 : 32'd1) : 32'd0);
        if (svc) chk("buf_raddr", 32'(buf_raddr), 32'(ra));
        chk("rd_valid", 32'(rd_valid), 32'(m_svc_prev));
        if (m_svc_prev) chk("rd_bank", 32'(rd_bank), 32'(m_svc_bank_prev));
        chk("frame_done", 32'(frame_done), 32'(rl));
        chk("underflow", 32'(underflow), 32'(m_under));
        chk("bank_full", 32'(bank_full),
            32'({m_fill[1] == DEPTH, m_fill[0] == DEPTH}));
        chk("wbank", 32'(debug.wbank), 32'(m_wbank));
        chk("rbank", 32'(debug.rbank), 32'(m_rbank));
        m_svc_prev = svc; m_svc_bank_prev = rb;
        acc_o = a;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        do_reset();
        step(1'b0, 32'd0, 1'b0, acc);   // wr_ready rises after this edge

        // One frame of pixels 1..8 into bank 0.
        next_pix = 32'd1;
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, next_pix, 1'b0, acc);
            if (acc) next_pix++;
        end
        chk("frame0_accepted", next_pix, 32'd9);

        // Second frame fills bank 1, then a held write stalls.
        for (int i = 0; i < DEPTH + 3; i++) begin
            step(1'b1, next_pix, 1'b0, acc);
            if (acc) next_pix++;
        end
        chk("stall_no_accept", next_pix, 32'd17);

        // Drain bank 0 with the write still held; it resumes once bank 0 empties.
        for (int i = 0; i < DEPTH + 2; i++) begin
            step(1'b1, next_pix, 1'b1, acc);
            if (acc) next_pix++;
        end

        // Drain bank 1 while filling bank 0 every cycle.
        for (int i = 0; i < DEPTH + 2; i++) begin
            step(1'b1, next_pix, 1'b1, acc);
            if (acc) next_pix++;
        end

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 3) != 0), {8'h00, 24'($urandom)},
                 1'($urandom_range(0, 2) == 0), acc);
        end

        // Read with both banks empty: sticky underflow.
        do_reset();
        step(1'b0, 32'd0, 1'b1, acc);
        for (int i = 0; i < 4; i++) step(1'b0, 32'd0, 1'b0, acc);

        // Reset mid-frame discards the partial fill.
        do_reset();
        step(1'b0, 32'd0, 1'b0, acc);
        for (int i = 0; i < 5; i++) step(1'b1, 32'h100 + 32'(i), 1'b0, acc);
        do_reset();
        step(1'b1, 32'h0000AB, 1'b0, acc);   // not ready yet
        step(1'b1, 32'h0000AB, 1'b0, acc);   // lands at bank 0 address 0
        chk("post_reset_accept", 32'(acc), 32'd1);
        step(1'b0, 32'd0, 1'b0, acc);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
